// File: rtl/sd_cmd_framer.sv
// sd_cmd_framer: SPI-mode SD command transmitter.
// Takes {cmd_index, argument} on a valid/ready handshake and serialises the
// 48-bit frame MSB first (0, 1, index, argument, CRC7, 1). Trailing '1' filler
// bits follow. The block generates its own SCK (mode 0) and drives CS_n.
// Ports:
//   clock, reset      system clock, asynchronous active-low reset
//   cmd_index/argument command payload, captured on accept
//   cmd_valid/ready    request handshake (ready only in IDLE)
//   keep_cs            captured on accept; 1 keeps cs_n low after done
//   sck, mosi, cs_n    card pins
//   busy, done         transaction status, done is a one-cycle pulse
module sd_cmd_framer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned TRAIL_BITS = 8,
  parameter bit          CRC_ENABLE = 1'b1,
  parameter logic [6:0]  CRC_FIXED  = 7'h4A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] argument,
  input  logic        cmd_valid,
  input  logic        keep_cs,
  output logic        cmd_ready,
  output logic        sck,
  output logic        mosi,
  output logic        cs_n,
  output logic        busy,
  output logic        done
);

  localparam int unsigned FRAME_BITS = 48;
  localparam int unsigned TOTAL_BITS = FRAME_BITS + TRAIL_BITS;
  localparam int unsigned BIT_W      = $clog2(TOTAL_BITS + 1);
  localparam int unsigned DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SR_W       = 39;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_PAYLOAD_LAST = BIT_W'(39);
  localparam logic [BIT_W-1:0] BIT_CRC_LAST     = BIT_W'(46);
  localparam logic [BIT_W-1:0] BIT_END          = BIT_W'(47);
  localparam logic [BIT_W-1:0] BIT_LAST         = BIT_W'(TOTAL_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    TRAIL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [SR_W-1:0]   sr, sr_nxt;
  logic [6:0]        crc, crc_nxt;
  logic              keep_q, keep_nxt;
  logic              sck_nxt, mosi_nxt, cs_n_nxt, busy_nxt, done_nxt;
  logic [6:0]        crc_step, crc_tail;
  logic              bit_end;

  assign cmd_ready = (state == IDLE);

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      crc     <= '0;
      keep_q  <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b1;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      sr      <= sr_nxt;
      crc     <= crc_nxt;
      keep_q  <= keep_nxt;
      sck     <= sck_nxt;
      mosi    <= mosi_nxt;
      cs_n    <= cs_n_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state, bit sequencing and CRC
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    sr_nxt    = sr;
    crc_nxt   = crc;
    keep_nxt  = keep_q;
    sck_nxt   = sck;
    mosi_nxt  = mosi;
    cs_n_nxt  = cs_n;
    done_nxt  = 1'b0;
    // mosi holds the bit currently on the wire, so it feeds the CRC at bit end
    crc_step  = {crc[5:0], 1'b0} ^ ((crc[6] ^ mosi) ? 7'h09 : 7'h00);
    crc_tail  = CRC_ENABLE ? crc_step : CRC_FIXED;
    bit_end   = (div_cnt == DIV_LAST);

    case (state)
      IDLE: begin
        sck_nxt  = 1'b0;
        mosi_nxt = 1'b1;
        if (cmd_valid) begin
          state_nxt = SEND;
          sr_nxt    = {1'b1, cmd_index, argument};
          keep_nxt  = keep_cs;
          crc_nxt   = '0;
          div_nxt   = '0;
          bit_nxt   = '0;
          mosi_nxt  = 1'b0;
          cs_n_nxt  = 1'b0;
        end
      end
      SEND, TRAIL: begin
        div_nxt = div_cnt + DIV_W'(1);
        if (div_cnt == HALF_LAST) sck_nxt = 1'b1;
        if (bit_end) begin
          div_nxt  = '0;
          sck_nxt  = 1'b0;
          bit_nxt  = bit_cnt + BIT_W'(1);
          mosi_nxt = 1'b1;
          if (state == SEND) begin
            if (bit_cnt < BIT_PAYLOAD_LAST) begin
              mosi_nxt = sr[SR_W-1];
              sr_nxt   = {sr[SR_W-2:0], 1'b0};
              crc_nxt  = crc_step;
            end else if (bit_cnt == BIT_PAYLOAD_LAST) begin
              // last payload bit folds into the CRC, whose MSB goes out next
              crc_nxt  = crc_tail;
              mosi_nxt = crc_tail[6];
            end else if (bit_cnt < BIT_CRC_LAST) begin
              mosi_nxt = crc[5];
              crc_nxt  = {crc[5:0], 1'b0};
            end
          end
          if (bit_cnt == BIT_LAST) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else if (bit_cnt == BIT_END) begin
            state_nxt = TRAIL;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        sck_nxt   = 1'b0;
        mosi_nxt  = 1'b1;
        cs_n_nxt  = ~keep_q;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Scoreboard bench for sd_cmd_framer: three instances (defaults, CRC disabled,
// CLK_DIV=2 with no trailing bits). Stimulus pushes expected frames; a monitor
// reassembles mosi on rising sck and checks each transaction at its done pulse.
module tb_sd_cmd_framer;

  typedef struct {
    int          inst;
    logic [63:0] bits;
    int          nbits;
    int          lat;
    logic        keep;
    logic        b2b;
    string       name;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [5:0]  cmd_index [3];
  logic [31:0] argument  [3];
  logic        cmd_valid [3];
  logic        keep_cs   [3];
  logic        cmd_ready [3];
  logic        sck       [3];
  logic        mosi      [3];
  logic        cs_n      [3];
  logic        busy      [3];
  logic        done      [3];

  exp_t        exp_q[$];
  exp_t        e_m;
  int          n_cmp;
  int          n_fail;
  int          cyc;
  bit          end_req;

  logic [63:0] rx        [3];
  int          rx_n      [3];
  bit          sck_q     [3];
  bit          cs_bad    [3];
  bit          post      [3];
  bit          post_cs   [3];
  int          acc_cyc   [3];
  int          last_done [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sd_cmd_framer #(
      .CLK_DIV    (g == 2 ? 2 : 4),
      .TRAIL_BITS (g == 2 ? 0 : 8),
      .CRC_ENABLE (g == 1 ? 1'b0 : 1'b1),
      .CRC_FIXED  (7'h4A)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_index (cmd_index[g]),
      .argument  (argument[g]),
      .cmd_valid (cmd_valid[g]),
      .keep_cs   (keep_cs[g]),
      .cmd_ready (cmd_ready[g]),
      .sck       (sck[g]),
      .mosi      (mosi[g]),
      .cs_n      (cs_n[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: all comparisons happen here, on the falling edge
  always @(negedge clock) begin
    if (end_req) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL queue_empty: %0d expected frames never completed", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        n_cmp++;
        if (sck[i] !== 1'b0 || mosi[i] !== 1'b1 || cs_n[i] !== 1'b1 ||
            busy[i] !== 1'b0 || done[i] !== 1'b0 || cmd_ready[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_outs inst%0d: got sck=%b mosi=%b cs_n=%b busy=%b done=%b ready=%b, want 0 1 1 0 0 1",
                   i, sck[i], mosi[i], cs_n[i], busy[i], done[i], cmd_ready[i]);
        end
        rx[i] = '0; rx_n[i] = 0; sck_q[i] = 1'b0; cs_bad[i] = 1'b0; post[i] = 1'b0;
      end else begin
        if (post[i]) begin
          n_cmp++;
          if (cmd_ready[i] !== 1'b1 || cs_n[i] !== post_cs[i]) begin
            n_fail++;
            $display("FAIL after_done inst%0d: got ready=%b cs_n=%b, want ready=1 cs_n=%b",
                     i, cmd_ready[i], cs_n[i], post_cs[i]);
          end
          post[i] = 1'b0;
        end
        if (cmd_valid[i] && cmd_ready[i]) begin
          acc_cyc[i] = cyc;
          if (exp_q.size() > 0 && exp_q[0].b2b) begin
            n_cmp++;
            if (cyc != last_done[i] + 1) begin
              n_fail++;
              $display("FAIL b2b_gap inst%0d: accept %0d cycles after done, want 1", i, cyc - last_done[i]);
            end
          end
        end
        if (sck[i] && !sck_q[i]) begin
          rx[i] = {rx[i][62:0], mosi[i]};
          rx_n[i]++;
          if (cs_n[i]) cs_bad[i] = 1'b1;
        end
        sck_q[i] = sck[i];
        if (done[i]) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done inst%0d: done with empty scoreboard", i);
          end else begin
            e_m = exp_q.pop_front();
            if (e_m.inst != i) begin
              n_fail++;
              $display("FAIL %s inst: done on inst%0d, want inst%0d", e_m.name, i, e_m.inst);
            end
            n_cmp++;
            if (rx_n[i] != e_m.nbits ||
                (rx[i] & ((64'd1 << e_m.nbits) - 64'd1)) != e_m.bits) begin
              n_fail++;
              $display("FAIL %s bits: got %0d bits %h, want %0d bits %h",
                       e_m.name, rx_n[i], rx[i], e_m.nbits, e_m.bits);
            end
            n_cmp++;
            if (cyc - acc_cyc[i] != e_m.lat) begin
              n_fail++;
              $display("FAIL %s latency: got %0d, want %0d", e_m.name, cyc - acc_cyc[i], e_m.lat);
            end
            n_cmp++;
            if (cs_bad[i] || sck[i] !== 1'b0 || mosi[i] !== 1'b1 ||
                busy[i] !== 1'b1 || cmd_ready[i] !== 1'b0) begin
              n_fail++;
              $display("FAIL %s done_outs: got cs_hi_in_frame=%b sck=%b mosi=%b busy=%b ready=%b, want 0 0 1 1 0",
                       e_m.name, cs_bad[i], sck[i], mosi[i], busy[i], cmd_ready[i]);
            end
            post_cs[i] = ~e_m.keep;
            post[i]    = 1'b1;
          end
          last_done[i] = cyc;
          rx[i] = '0; rx_n[i] = 0; cs_bad[i] = 1'b0;
        end
      end
    end
  end

  task automatic push(input int i, input logic [47:0] frame, input logic keep,
                      input logic b2b, input string name);
    exp_t e;
    int   t;
    int   d;
    t = (i == 2) ? 0 : 8;
    d = (i == 2) ? 2 : 4;
    e.inst  = i;
    e.bits  = ({16'h0, frame} << t) | ((64'd1 << t) - 64'd1);
    e.nbits = 48 + t;
    e.lat   = 1 + (48 + t) * d;
    e.keep  = keep;
    e.b2b   = b2b;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_accept(input int i);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (cmd_ready[i]) begin
        @(posedge clock);
        #1;
        return;
      end
    end
    $display("FAIL accept_timeout inst%0d: cmd_ready never seen", i);
    $fatal(1, "accept timeout");
  endtask

  task automatic wait_done(input int i);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (done[i]) begin
        @(posedge clock);
        #1;
        return;
      end
    end
    $display("FAIL done_timeout inst%0d: done never seen", i);
    $fatal(1, "done timeout");
  endtask

  task automatic run(input int i, input logic [5:0] idx, input logic [31:0] arg,
                     input logic keep, input logic [47:0] frame, input string name);
    push(i, frame, keep, 1'b0, name);
    cmd_index[i] = idx;
    argument[i]  = arg;
    keep_cs[i]   = keep;
    cmd_valid[i] = 1'b1;
    wait_accept(i);
    cmd_valid[i] = 1'b0;
    wait_done(i);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; end_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_index[i] = '0; argument[i] = '0; cmd_valid[i] = 1'b0; keep_cs[i] = 1'b0;
      rx[i] = '0; rx_n[i] = 0; sck_q[i] = 1'b0; cs_bad[i] = 1'b0;
      post[i] = 1'b0; post_cs[i] = 1'b1; acc_cyc[i] = 0; last_done[i] = 0;
    end
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    run(0, 6'd0,  32'h0,     1'b0, 48'h40_0000_0000_95, "cmd0");
    run(0, 6'd8,  32'h1AA,   1'b0, 48'h48_0000_01AA_87, "cmd8");
    run(0, 6'd17, 32'h0,     1'b0, 48'h51_0000_0000_55, "cmd17");
    run(0, 6'd55, 32'h0,     1'b1, 48'h77_0000_0000_65, "cmd55_keep");
    repeat (5) @(posedge clock);
    #1;
    run(0, 6'd0,  32'h0,     1'b0, 48'h40_0000_0000_95, "cmd0_release");

    // Reset asserted in the middle of bit 20 of a CMD8 frame
    cmd_index[0] = 6'd8; argument[0] = 32'h1AA; keep_cs[0] = 1'b0; cmd_valid[0] = 1'b1;
    wait_accept(0);
    cmd_valid[0] = 1'b0;
    repeat (81) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    run(0, 6'd0,  32'h0,     1'b0, 48'h40_0000_0000_95, "cmd0_after_reset");

    // cmd_valid held high, payload changed while the first frame is in flight
    push(0, 48'h51_0000_0000_55, 1'b0, 1'b0, "b2b_first");
    cmd_index[0] = 6'd17; argument[0] = 32'h0; keep_cs[0] = 1'b0; cmd_valid[0] = 1'b1;
    wait_accept(0);
    cmd_index[0] = 6'd8; argument[0] = 32'h1AA;
    push(0, 48'h48_0000_01AA_87, 1'b0, 1'b1, "b2b_second");
    wait_done(0);
    wait_accept(0);
    cmd_valid[0] = 1'b0;
    wait_done(0);

    run(1, 6'd8,  32'h1AA,   1'b0, 48'h48_0000_01AA_95, "nocrc_cmd8");
    run(2, 6'd0,  32'h0,     1'b0, 48'h40_0000_0000_95, "div2_cmd0");

    repeat (3) @(posedge clock);
    #1 end_req = 1'b1;
    repeat (4) @(posedge clock);
    $display("FAIL end_of_test: monitor did not finish");
    $fatal(1, "monitor stalled");
  end

endmodule
